// File: rtl/vga_timing_sequencer.sv
// vga_timing_sequencer: VGA raster timing generator.
// Pixel-rate divider, h/v counters, registered video/sync decode.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-low reset
//   enable      raster run request (level, synchronous)
//   hCounter    current pixel column, 0..H_TOTAL-1
//   vCounter    current line, 0..V_TOTAL-1
//   vidOn       inside the visible window
//   hsync_n     horizontal sync, active low
//   vsync_n     vertical sync, active low
//   pixel_tick  one-clk strobe per pixel advance
//   line_start  one-clk strobe when hCounter becomes 0
//   frame_start one-clk strobe when position becomes (0,0)
//   running     raster is in the RUN state
module vga_timing_sequencer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  output logic [9:0] hCounter,
  output logic [9:0] vCounter,
  output logic       vidOn,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       pixel_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic       running
);

  localparam int H_TOTAL =
    H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam int DIV_W =
    (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST =
    10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST =
    10'(V_TOTAL - 1);

  // 11-bit bounds so a 1024-wide total still compares cleanly
  localparam logic [10:0] H_VIS_L =
    11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG_L =
    11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END_L =
    11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_L =
    11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG_L =
    11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END_L =
    11'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;

  logic w_idle;
  logic w_tick;
  logic w_hwrap;
  logic w_last;
  logic w_park;
  logic w_adv;

  logic [9:0]  w_h_adv;
  logic [9:0]  w_v_adv;
  logic [10:0] w_h_ext;
  logic [10:0] w_v_ext;
  logic        w_vid_adv;
  logic        w_hs_adv;
  logic        w_vs_adv;

  logic [9:0] w_h_nxt;
  logic [9:0] w_v_nxt;
  logic       w_vid_nxt;
  logic       w_hs_nxt;
  logic       w_vs_nxt;
  logic       w_tick_nxt;
  logic       w_ls_nxt;
  logic       w_fs_nxt;
  logic       w_run_nxt;

  assign w_idle  = (r_state == S_IDLE);
  assign w_tick  = (r_state == S_RUN) &&
                   (r_div == DIV_LAST);
  assign w_hwrap = (hCounter == H_LAST);
  assign w_last  = w_hwrap &&
                   (vCounter == V_LAST);

  // the frame-completing tick parks instead
  // of wrapping when the run request is gone
  assign w_park = w_tick && w_last && !enable;
  assign w_adv  = w_tick && !w_park;

  assign w_h_adv = w_hwrap ? 10'd0
                           : hCounter + 10'd1;

  always_comb begin
    w_v_adv = vCounter;
    if (w_hwrap) begin
      if (vCounter == V_LAST)
        w_v_adv = 10'd0;
      else
        w_v_adv = vCounter + 10'd1;
    end
  end

  // decode from the next position so the
  // registered flags line up with the counters
  assign w_h_ext = {1'b0, w_h_adv};
  assign w_v_ext = {1'b0, w_v_adv};

  assign w_vid_adv = (w_h_ext < H_VIS_L) &&
                     (w_v_ext < V_VIS_L);
  assign w_hs_adv  = !((w_h_ext >= HS_BEG_L) &&
                       (w_h_ext <  HS_END_L));
  assign w_vs_adv  = !((w_v_ext >= VS_BEG_L) &&
                       (w_v_ext <  VS_END_L));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (enable)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_park)
          w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_div_nxt  = r_div;
    w_h_nxt    = hCounter;
    w_v_nxt    = vCounter;
    w_vid_nxt  = vidOn;
    w_hs_nxt   = hsync_n;
    w_vs_nxt   = vsync_n;
    w_tick_nxt = 1'b0;
    w_ls_nxt   = 1'b0;
    w_fs_nxt   = 1'b0;
    w_run_nxt  = (w_state_nxt == S_RUN);
    unique case (1'b1)
      w_idle, w_park: begin
        w_div_nxt = '0;
        w_h_nxt   = H_LAST;
        w_v_nxt   = V_LAST;
        w_vid_nxt = 1'b0;
        w_hs_nxt  = 1'b1;
        w_vs_nxt  = 1'b1;
      end
      w_adv: begin
        w_div_nxt  = '0;
        w_h_nxt    = w_h_adv;
        w_v_nxt    = w_v_adv;
        w_vid_nxt  = w_vid_adv;
        w_hs_nxt   = w_hs_adv;
        w_vs_nxt   = w_vs_adv;
        w_tick_nxt = 1'b1;
        w_ls_nxt   = (w_h_adv == 10'd0);
        w_fs_nxt   = (w_h_adv == 10'd0) &&
                     (w_v_adv == 10'd0);
      end
      default: begin
        w_div_nxt = r_div + 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div       <= '0;
      hCounter    <= H_LAST;
      vCounter    <= V_LAST;
      vidOn       <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      pixel_tick  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      r_div       <= w_div_nxt;
      hCounter    <= w_h_nxt;
      vCounter    <= w_v_nxt;
      vidOn       <= w_vid_nxt;
      hsync_n     <= w_hs_nxt;
      vsync_n     <= w_vs_nxt;
      pixel_tick  <= w_tick_nxt;
      line_start  <= w_ls_nxt;
      frame_start <= w_fs_nxt;
      running     <= w_run_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// tb_vga_timing_sequencer: bench for vga_timing_sequencer.
// Default, tiny and medium raster instances against a position model.
module tb_vga_timing_sequencer;

  typedef struct packed {
    logic [9:0] hc;
    logic [9:0] vc;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       tick;
    logic       ls;
    logic       fs;
    logic       run;
  } obs_t;

  typedef struct {
    int hvis; int hfp; int hsy; int ht;
    int vvis; int vfp; int vsy; int vt;
    int div;
    bit run; int phase; int pos;
    bit tick; bit ls; bit fs;
  } mdl_t;

  typedef struct {
    logic en;
    obs_t exp;
  } vec_t;

  localparam int D_HT = 640 + 16 + 96 + 48;
  localparam int D_VT = 480 + 10 + 2 + 33;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_d  = 1'b0;
  logic en_s  = 1'b0;
  logic en_m  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mdl_t md, ms, mm;
  vec_t tbl[10];

  logic [9:0] d_hc, d_vc, s_hc, s_vc, m_hc, m_vc;
  logic d_vid, d_hs, d_vs, d_tk, d_ls, d_fs, d_run;
  logic s_vid, s_hs, s_vs, s_tk, s_ls, s_fs, s_run;
  logic m_vid, m_hs, m_vs, m_tk, m_ls, m_fs, m_run;
  obs_t o_d, o_s, o_m;

  assign o_d = {d_hc, d_vc, d_vid, d_hs, d_vs,
                d_tk, d_ls, d_fs, d_run};
  assign o_s = {s_hc, s_vc, s_vid, s_hs, s_vs,
                s_tk, s_ls, s_fs, s_run};
  assign o_m = {m_hc, m_vc, m_vid, m_hs, m_vs,
                m_tk, m_ls, m_fs, m_run};

  always #5 clk = ~clk;

  vga_timing_sequencer dut_d (
    .clk(clk), .reset(rst_n), .enable(en_d),
    .hCounter(d_hc), .vCounter(d_vc),
    .vidOn(d_vid), .hsync_n(d_hs), .vsync_n(d_vs),
    .pixel_tick(d_tk), .line_start(d_ls),
    .frame_start(d_fs), .running(d_run));

  vga_timing_sequencer #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1)
  ) dut_s (
    .clk(clk), .reset(rst_n), .enable(en_s),
    .hCounter(s_hc), .vCounter(s_vc),
    .vidOn(s_vid), .hsync_n(s_hs), .vsync_n(s_vs),
    .pixel_tick(s_tk), .line_start(s_ls),
    .frame_start(s_fs), .running(s_run));

  vga_timing_sequencer #(
    .H_VISIBLE(5), .H_FRONT(2), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(3)
  ) dut_m (
    .clk(clk), .reset(rst_n), .enable(en_m),
    .hCounter(m_hc), .vCounter(m_vc),
    .vidOn(m_vid), .hsync_n(m_hs), .vsync_n(m_vs),
    .pixel_tick(m_tk), .line_start(m_ls),
    .frame_start(m_fs), .running(m_run));

  function automatic mdl_t mk(
    input int hv, input int hf, input int hs, input int hb,
    input int vv, input int vf, input int vs, input int vb,
    input int dv);
    mdl_t m;
    m.hvis = hv; m.hfp = hf; m.hsy = hs;
    m.ht   = hv + hf + hs + hb;
    m.vvis = vv; m.vfp = vf; m.vsy = vs;
    m.vt   = vv + vf + vs + vb;
    m.div  = dv;
    m.run  = 0; m.phase = 0;
    m.pos  = m.ht * m.vt - 1;
    m.tick = 0; m.ls = 0; m.fs = 0;
    return m;
  endfunction

  function automatic mdl_t m_rst(input mdl_t m);
    m.run  = 0; m.phase = 0;
    m.pos  = m.ht * m.vt - 1;
    m.tick = 0; m.ls = 0; m.fs = 0;
    return m;
  endfunction

  // position is a linear pixel index within the frame
  function automatic mdl_t m_step(input mdl_t m, input logic en);
    int last;
    last = m.ht * m.vt - 1;
    m.tick = 0; m.ls = 0; m.fs = 0;
    if (!m.run) begin
      if (en) begin
        m.run = 1; m.phase = 0;
      end
    end else if (m.phase < m.div - 1) begin
      m.phase++;
    end else begin
      m.phase = 0;
      if (m.pos == last && !en) begin
        m.run = 0;
      end else begin
        m.pos  = (m.pos + 1) % (last + 1);
        m.tick = 1;
        m.ls   = (m.pos % m.ht) == 0;
        m.fs   = (m.pos == 0);
      end
    end
    return m;
  endfunction

  function automatic obs_t m_obs(input mdl_t m);
    obs_t o;
    int h, v, hb, vb;
    h  = m.pos % m.ht;
    v  = m.pos / m.ht;
    hb = m.hvis + m.hfp;
    vb = m.vvis + m.vfp;
    o.hc   = 10'(h);
    o.vc   = 10'(v);
    o.tick = m.tick;
    o.ls   = m.ls;
    o.fs   = m.fs;
    o.run  = m.run;
    o.vid  = 1'b0;
    o.hs   = 1'b1;
    o.vs   = 1'b1;
    if (m.run) begin
      o.vid = (h < m.hvis) && (v < m.vvis);
      o.hs  = !(h >= hb && h < hb + m.hsy);
      o.vs  = !(v >= vb && v < vb + m.vsy);
    end
    return o;
  endfunction

  function automatic obs_t mo(
    input int h, input int v, input bit vid, input bit hs,
    input bit vs, input bit tk, input bit ls, input bit fs,
    input bit rn);
    obs_t o;
    o = {10'(h), 10'(v), vid, hs, vs, tk, ls, fs, rn};
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t g, input obs_t e);
    n_tests++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t got hc=%0d vc=%0d vid=%b hs_n=%b vs_n=%b tick=%b ls=%b fs=%b run=%b, want hc=%0d vc=%0d vid=%b hs_n=%b vs_n=%b tick=%b ls=%b fs=%b run=%b",
        nm, $time, g.hc, g.vc, g.vid, g.hs, g.vs, g.tick, g.ls,
        g.fs, g.run, e.hc, e.vc, e.vid, e.hs, e.vs, e.tick,
        e.ls, e.fs, e.run);
    end
  endtask

  task automatic chk(input string nm, input int g, input int e);
    n_tests++;
    if (g != e) begin
      n_fail++;
      $display("FAIL %s t=%0t got %0d want %0d", nm, $time, g, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    md = m_step(md, en_d);
    ms = m_step(ms, en_s);
    mm = m_step(mm, en_m);
    #1;
    cmp("model_d", o_d, m_obs(md));
    cmp("model_s", o_s, m_obs(ms));
    cmp("model_m", o_m, m_obs(mm));
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    md = m_rst(md);
    ms = m_rst(ms);
    mm = m_rst(mm);
    #1;
    cmp("async_rst_d", o_d, m_obs(md));
    cmp("async_rst_s", o_s, m_obs(ms));
    cmp("async_rst_m", o_m, m_obs(mm));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, per, cnt_a, cnt_b, cnt_c, lo, hi, vmax, hmax;

    assert (D_HT <= 1024 && D_VT <= 1024)
      else $fatal(1, "FAIL param_range H_TOTAL=%0d V_TOTAL=%0d", D_HT, D_VT);

    md = mk(640, 16, 96, 48, 480, 10, 2, 33, 2);
    ms = mk(4, 1, 1, 1, 3, 1, 1, 1, 1);
    mm = mk(5, 2, 2, 1, 4, 1, 2, 1, 3);

    // tiny raster: H 4/1/1/1 (7), V 3/1/1/1 (6), CLK_DIV 1
    tbl[0] = '{1'b0, mo(6, 5, 0, 1, 1, 0, 0, 0, 0)};
    tbl[1] = '{1'b1, mo(6, 5, 0, 1, 1, 0, 0, 0, 1)};
    tbl[2] = '{1'b1, mo(0, 0, 1, 1, 1, 1, 1, 1, 1)};
    tbl[3] = '{1'b1, mo(1, 0, 1, 1, 1, 1, 0, 0, 1)};
    tbl[4] = '{1'b0, mo(2, 0, 1, 1, 1, 1, 0, 0, 1)};
    tbl[5] = '{1'b0, mo(3, 0, 1, 1, 1, 1, 0, 0, 1)};
    tbl[6] = '{1'b0, mo(4, 0, 0, 1, 1, 1, 0, 0, 1)};
    tbl[7] = '{1'b0, mo(5, 0, 0, 0, 1, 1, 0, 0, 1)};
    tbl[8] = '{1'b0, mo(6, 0, 0, 1, 1, 1, 0, 0, 1)};
    tbl[9] = '{1'b1, mo(0, 1, 1, 1, 1, 1, 1, 0, 1)};

    repeat (3) @(negedge clk);
    cmp("reset_d", o_d, mo(799, 524, 0, 1, 1, 0, 0, 0, 0));
    cmp("reset_s", o_s, m_obs(ms));
    cmp("reset_m", o_m, m_obs(mm));
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      en_s = tbl[i].en;
      step();
      cmp($sformatf("tbl[%0d]", i), o_s, tbl[i].exp);
    end

    // first frame at default timing
    en_d = 1'b1;
    step();
    chk("t1_running", int'(d_run), 1);
    chk("t1_no_tick_a", int'(d_tk), 0);
    step();
    chk("t1_no_tick_b", int'(d_tk), 0);
    step();
    cmp("t1_first_tick", o_d, mo(0, 0, 1, 1, 1, 1, 1, 1, 1));

    // one full line at default timing
    cnt_a = int'(d_vid);
    cnt_b = int'(!d_hs);
    per = -1; lo = 1023; hi = -1; hmax = 0;
    for (int i = 1; i <= 1600; i++) begin
      step();
      if (d_ls && per < 0) per = i;
      if (i < 1600) begin
        cnt_a += int'(d_vid);
        cnt_b += int'(!d_hs);
        if (!d_hs && int'(d_hc) < lo) lo = int'(d_hc);
        if (!d_hs && int'(d_hc) > hi) hi = int'(d_hc);
        if (d_vid && int'(d_hc) > hmax) hmax = int'(d_hc);
      end
    end
    chk("t2_vid_clks", cnt_a, 1280);
    chk("t2_vid_last_col", hmax, 639);
    chk("t2_hsync_clks", cnt_b, 192);
    chk("t2_hsync_first", lo, 656);
    chk("t2_hsync_last", hi, 751);
    chk("t2_line_period", per, 1600);

    // drop enable mid-frame on the tiny raster
    n = 0;
    while (!(s_hc == 10'd2 && s_vc == 10'd1) && n < 200) begin
      step(); n++;
    end
    chk("t4_reach_2_1", int'(s_hc == 10'd2 && s_vc == 10'd1), 1);
    en_s = 1'b0;
    n = 0;
    while (s_run && n < 100) begin
      step(); n++;
    end
    chk("t4_park_clks", n, 33);
    chk("t4_park_hc", int'(s_hc), 6);
    chk("t4_park_vc", int'(s_vc), 5);
    chk("t4_park_fs", int'(s_fs), 0);
    chk("t4_park_vid", int'(s_vid), 0);
    repeat (4) step();
    chk("t4_hold_hc", int'(s_hc), 6);
    chk("t4_hold_tick", int'(s_tk), 0);

    // brief enable glitch must not disturb the frame
    en_s = 1'b1;
    n = 0;
    while (!s_fs && n < 100) begin
      step(); n++;
    end
    chk("t5_restart_fs", int'(s_fs), 1);
    per = -1; cnt_a = 0; cnt_b = 0;
    for (int i = 1; i <= 60; i++) begin
      en_s = !(i >= 10 && i < 13);
      step();
      if (!s_run) cnt_a++;
      if (i <= 42) cnt_b += int'(s_tk);
      if (s_fs && per < 0) per = i;
    end
    chk("t5_frame_period", per, 42);
    chk("t5_run_drops", cnt_a, 0);
    chk("t5_ticks", cnt_b, 42);

    // async reset mid-frame at default timing
    n = 0;
    while (d_hc != 10'd400 && n < 2000) begin
      step(); n++;
    end
    chk("t6_reach_col", int'(d_hc), 400);
    pulse_reset();
    chk("t6_rst_hc", int'(d_hc), 799);
    chk("t6_rst_vc", int'(d_vc), 524);
    chk("t6_rst_vid", int'(d_vid), 0);
    chk("t6_rst_sync", int'({d_hs, d_vs}), 3);
    step();
    chk("t6_fs_a", int'(d_fs), 0);
    step();
    chk("t6_fs_b", int'(d_fs), 0);
    step();
    cmp("t6_fs_c", o_d, mo(0, 0, 1, 1, 1, 1, 1, 1, 1));

    // full frame on the medium raster
    en_m = 1'b1;
    n = 0;
    while (!m_fs && n < 300) begin
      step(); n++;
    end
    chk("t3_first_fs", int'(m_fs), 1);
    per = -1; cnt_a = int'(!m_vs);
    lo = 1023; hi = -1; hmax = 0; vmax = 0;
    for (int i = 1; i <= 240; i++) begin
      step();
      if (m_fs && per < 0) per = i;
      if (int'(m_hc) > hmax) hmax = int'(m_hc);
      if (int'(m_vc) > vmax) vmax = int'(m_vc);
      if (i < 240) cnt_a += int'(!m_vs);
      if (!m_vs && int'(m_vc) < lo) lo = int'(m_vc);
      if (!m_vs && int'(m_vc) > hi) hi = int'(m_vc);
    end
    chk("t3_frame_period", per, 240);
    chk("t3_vsync_clks", cnt_a, 60);
    chk("t3_vsync_first", lo, 5);
    chk("t3_vsync_last", hi, 6);
    chk("t3_hmax", hmax, 9);
    chk("t3_vmax", vmax, 7);

    // random enable traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en_d = !en_d;
      if ($urandom_range(0, 15) == 0) en_s = !en_s;
      if ($urandom_range(0, 15) == 0) en_m = !en_m;
      if ($urandom_range(0, 700) == 0) pulse_reset();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
